seven_seg_mux: RTL and testbench
================================

Name: seven_seg_mux

Overview:
- 4-digit multiplexed 7-segment display driver.
- Captures four BCD digits (units, tens, hundreds, thousands) when the upstream converter strobes `listo`.
- Time-multiplexes those digits onto one shared segment bus with per-digit transistor enables.
- Sits between the binary-to-BCD stage and the board's display pins.

Parameters:
- REFRESH_DIV, 27000, clk cycles each digit stays lit before the scan advances (~1 kHz/digit at 27 MHz); minimum 1; benches override to 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- unidades_input  input  4  BCD units digit.
- decenas_input  input  4  BCD tens digit.
- centenas_input  input  4  BCD hundreds digit.
- millares_input  input  4  BCD thousands digit.
- listo  input  1  data-valid strobe; when high, all four digits are captured.
- seg  output  7  segment drive, active-low, seg[0]=a … seg[6]=g.
- transis  output  4  digit enables, active-low, one-hot-low; transis[0]=units … transis[3]=thousands.

Behaviour:
- Reset (rst==0 at a rising edge):
  - digit registers cleared to 0; divider cleared to 0; scan index cleared to 0.
  - seg=7'b1111111 and transis=4'b1111 (all dark).
  - Reset has priority over `listo`.
- Capture:
  - At each edge with rst==1 and listo==1, all four inputs are registered together.
  - `listo` held high recaptures every cycle.
  - When listo==0, the stored digits hold indefinitely.
- Divider:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - A tick is asserted when the count equals REFRESH_DIV-1.
  - On a tick, the scan index advances 0→1→2→3→0 (2-bit wrap).
- Outputs are registered. Each edge (rst==1) loads:
  - transis: index0=4'b1110, index1=4'b1101, index2=4'b1011, index3=4'b0111.
  - seg = decode(stored digit selected by the index: 0=units, 1=tens, 2=hundreds, 3=thousands).
- Latency:
  - A capture at edge N is visible on seg at edge N+1 whenever that digit is selected.
  - An index change at edge N is visible at edge N+1.
  - seg and transis always change on the same edge, so there is no cross-digit mismatch.
- First edge after reset release: transis=4'b1110, seg=7'b1000000 (digit 0 shown).
- Decode (active-low, bit6..bit0 = g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - 10..15 = 1111111 (blank).
- Leading zeros are displayed, not blanked.
- Reset asserted mid-scan returns to the reset state on that edge; the scan restarts at index 0.

Decomposition:
- Shared package seg_pkg holds:
  - the SEG_BLANK constant;
  - the digit-enable constants for indices 0..3;
  - a function `bcd_to_seg(logic [3:0]) -> logic [6:0]` implementing the decode table.
- One natural sub-module: bcd_to_7seg (combinational decoder, 4-bit in, 7-bit out).
- Capture registers, divider, scan counter and output registers stay in seven_seg_mux.

Test Plan (REFRESH_DIV=2):
- Reset: rst=0 for 2 cycles → seg=1111111, transis=1111; first edge after release → transis=1110, seg=1000000.
- Scan order, all digits 0: transis sequence 1110,1101,1011,0111,1110, each held 2 cycles; seg=1000000 throughout.
- Capture 7609 (u=9, d=0, c=6, m=7) with a 1-cycle listo pulse → per digit: 1110/0010000, 1101/1000000, 1011/0000010, 0111/1111000.
- Hold and recapture:
  - after listo drops, change inputs to 3193 without a strobe → display stays 7609;
  - then pulse listo → 1110/0110000, 1101/0010000, 1011/1111001, 0111/0110000.
- Leading zeros and blank:
  - capture 0094 → 0111 and 1011 show 1000000; 1101 shows 0010000; 1110 shows 0011001;
  - capture u=4'hA → that digit shows 1111111.
- Priority: rst=0 and listo=1 on the same edge → digits stay 0, outputs dark; listo asserted mid-scan updates only the stored values, not the scan index.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and BCD decode table for the multiplexed 7-segment display path.
// Segment vectors are active-low, bit6..bit0 = g..a.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] DIG_OFF   = 4'b1111;
    localparam logic [3:0] DIG_EN_0  = 4'b1110;
    localparam logic [3:0] DIG_EN_1  = 4'b1101;
    localparam logic [3:0] DIG_EN_2  = 4'b1011;
    localparam logic [3:0] DIG_EN_3  = 4'b0111;

    // Codes 10..15 are not valid BCD and are shown dark rather than as hex glyphs.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] pattern;
        case (bcd)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder.
module bcd_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = bcd_to_seg(bcd);

endmodule

// File: rtl/seven_seg_mux.sv
// 4-digit multiplexed 7-segment driver: captures BCD digits on listo and scans them
// onto a shared segment bus with active-low per-digit enables.
module seven_seg_mux
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 27000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] unidades_input,
    input  logic [3:0] decenas_input,
    input  logic [3:0] centenas_input,
    input  logic [3:0] millares_input,
    input  logic       listo,
    output logic [6:0] seg,
    output logic [3:0] transis
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [3:0]       digit_q [4];
    logic [CNT_W-1:0] div_cnt;
    logic [1:0]       scan_idx;
    logic             tick;
    logic [3:0]       sel_digit;
    logic [6:0]       sel_seg;
    logic [3:0]       sel_en;

    // Capture stage: all four digits are taken together so the display never mixes two values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) digit_q[i] <= 4'd0;
        end else if (listo) begin
            digit_q[0] <= unidades_input;
            digit_q[1] <= decenas_input;
            digit_q[2] <= centenas_input;
            digit_q[3] <= millares_input;
        end
    end

    assign tick = (div_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt  <= '0;
            scan_idx <= 2'd0;
        end else if (tick) begin
            div_cnt  <= '0;
            scan_idx <= scan_idx + 2'd1;
        end else begin
            div_cnt  <= div_cnt + CNT_W'(1);
        end
    end

    assign sel_digit = digit_q[scan_idx];

    bcd_to_7seg u_dec (
        .bcd (sel_digit),
        .seg (sel_seg)
    );

    always_comb begin
        sel_en = DIG_OFF;
        case (scan_idx)
            2'd0: sel_en = DIG_EN_0;
            2'd1: sel_en = DIG_EN_1;
            2'd2: sel_en = DIG_EN_2;
            2'd3: sel_en = DIG_EN_3;
            default: sel_en = DIG_OFF;
        endcase
    end

    // Output stage: seg and transis load from the same index on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            seg     <= SEG_BLANK;
            transis <= DIG_OFF;
        end else begin
            seg     <= sel_seg;
            transis <= sel_en;
        end
    end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Directed self-checking bench for seven_seg_mux with REFRESH_DIV=2.
module tb_seven_seg_mux;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] unidades_input = 4'd0;
    logic [3:0] decenas_input  = 4'd0;
    logic [3:0] centenas_input = 4'd0;
    logic [3:0] millares_input = 4'd0;
    logic       listo = 1'b0;
    logic [6:0] seg;
    logic [3:0] transis;

    int checks = 0;
    int errors = 0;

    seven_seg_mux #(.REFRESH_DIV(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .unidades_input (unidades_input),
        .decenas_input  (decenas_input),
        .centenas_input (centenas_input),
        .millares_input (millares_input),
        .listo          (listo),
        .seg            (seg),
        .transis        (transis)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advances (bounded) until the given digit enable is on the pins; does no checking.
    task automatic wait_digit(input logic [3:0] pat, output bit found);
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (transis === pat) begin
                found = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic set_digits(input logic [3:0] m, input logic [3:0] c,
                              input logic [3:0] d, input logic [3:0] u);
        millares_input = m;
        centenas_input = c;
        decenas_input  = d;
        unidades_input = u;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++;
        if (seg !== 7'b1111111 || transis !== 4'b1111) begin
            errors++;
            $display("FAIL reset_dark: seg=%b transis=%b expected seg=1111111 transis=1111", seg, transis);
        end
        rst = 1'b1;
        step();
        checks++;
        if (seg !== 7'b1000000 || transis !== 4'b1110) begin
            errors++;
            $display("FAIL reset_first_edge: seg=%b transis=%b expected seg=1000000 transis=1110", seg, transis);
        end
    endtask

    // Continues straight from the first post-reset edge.
    task automatic test_scan_order();
        logic [3:0] exp_t [9];
        exp_t = '{4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011,
                  4'b0111, 4'b0111, 4'b1110, 4'b1110};
        for (int i = 0; i < 9; i++) begin
            step();
            checks++;
            if (transis !== exp_t[i] || seg !== 7'b1000000) begin
                errors++;
                $display("FAIL scan_order[%0d]: transis=%b seg=%b expected transis=%b seg=1000000",
                         i, transis, seg, exp_t[i]);
            end
        end
    endtask

    task automatic test_digits(input string name, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3);
        logic [3:0] pats [4];
        logic [6:0] exps [4];
        bit found;
        pats = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exps = '{s0, s1, s2, s3};
        for (int k = 0; k < 4; k++) begin
            wait_digit(pats[k], found);
            checks++;
            if (!found || seg !== exps[k]) begin
                errors++;
                $display("FAIL %s_digit%0d: found=%0d transis=%b seg=%b expected seg=%b",
                         name, k, found, transis, seg, exps[k]);
            end
        end
    endtask

    task automatic test_capture();
        set_digits(4'd7, 4'd6, 4'd0, 4'd9);
        listo = 1'b1;
        step();
        listo = 1'b0;
        test_digits("cap7609", 7'b0010000, 7'b1000000, 7'b0000010, 7'b1111000);
    endtask

    task automatic test_hold_recapture();
        set_digits(4'd3, 4'd1, 4'd9, 4'd3);
        step();
        test_digits("hold7609", 7'b0010000, 7'b1000000, 7'b0000010, 7'b1111000);
        listo = 1'b1;
        step();
        listo = 1'b0;
        test_digits("cap3193", 7'b0110000, 7'b0010000, 7'b1111001, 7'b0110000);
    endtask

    task automatic test_leading_zero_blank();
        set_digits(4'd0, 4'd0, 4'd9, 4'd4);
        listo = 1'b1;
        step();
        listo = 1'b0;
        test_digits("cap0094", 7'b0011001, 7'b0010000, 7'b1000000, 7'b1000000);
        set_digits(4'd0, 4'd0, 4'd0, 4'hA);
        listo = 1'b1;
        step();
        listo = 1'b0;
        test_digits("blankA", 7'b1111111, 7'b1000000, 7'b1000000, 7'b1000000);
    endtask

    task automatic test_priority();
        set_digits(4'd8, 4'd8, 4'd8, 4'd8);
        rst = 1'b0;
        listo = 1'b1;
        step();
        checks++;
        if (seg !== 7'b1111111 || transis !== 4'b1111) begin
            errors++;
            $display("FAIL prio_dark: seg=%b transis=%b expected seg=1111111 transis=1111", seg, transis);
        end
        listo = 1'b0;
        rst = 1'b1;
        step();
        checks++;
        if (seg !== 7'b1000000 || transis !== 4'b1110) begin
            errors++;
            $display("FAIL prio_restart: seg=%b transis=%b expected seg=1000000 transis=1110", seg, transis);
        end
        test_digits("prio_zero", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
    endtask

    task automatic test_midscan_listo();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        step();
        step();
        // Third edge after release: tens digit lit for its first cycle.
        checks++;
        if (transis !== 4'b1101) begin
            errors++;
            $display("FAIL midscan_pre: transis=%b expected 1101", transis);
        end
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        listo = 1'b1;
        step();
        listo = 1'b0;
        checks++;
        if (transis !== 4'b1101 || seg !== 7'b1000000) begin
            errors++;
            $display("FAIL midscan_hold: transis=%b seg=%b expected transis=1101 seg=1000000", transis, seg);
        end
        step();
        checks++;
        if (transis !== 4'b1011 || seg !== 7'b0100100) begin
            errors++;
            $display("FAIL midscan_next: transis=%b seg=%b expected transis=1011 seg=0100100", transis, seg);
        end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_capture();
        test_hold_recapture();
        test_leading_zero_blank();
        test_priority();
        test_midscan_listo();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
